// File: rtl/inttofp_arb.sv
// inttofp_arb: round-robin arbiter sharing one int-to-fp converter among NREQ requesters,
// with a per-requester result buffer and a completed-conversion counter.
module inttofp_arb #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_data,
  input  logic [NREQ*5-1:0]    req_cru,
  input  logic                 en,
  output logic [127:0]         cv_src,
  output logic [5:0]           cv_cru,
  input  logic [127:0]         cv_res,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*128-1:0]  rsp_data,
  output logic [15:0]          conv_cnt
);
  localparam int LW = $clog2(NREQ);
  logic [NREQ-1:0][127:0] rd, rsp_data_q;
  logic [NREQ-1:0][4:0] rc;
  logic [NREQ-1:0] busy_q, rsp_valid_q, elig, gnt, done, wr;
  logic [LW-1:0] last_q, gid, idx;
  logic [LW:0] itag_q, rtag_q;
  logic [127:0] cv_src_q;
  logic [5:0] cv_cru_q;
  logic [15:0] cnt_q;
  assign rd = req_data;
  assign rc = req_cru;
  assign elig = req_valid & ~busy_q & {NREQ{en & rst_n}};
  assign done = rsp_valid_q & rsp_ready;
  assign wr = rtag_q[LW] ? NREQ'(1) << rtag_q[LW-1:0] : '0;
  // Scan farthest-first so the requester nearest after last_q wins the final overwrite.
  always_comb begin
    gnt = '0;
    gid = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = LW'((int'(last_q) + k) % NREQ);
      gnt = elig[idx] ? NREQ'(1) << idx : gnt;
      gid = elig[idx] ? idx : gid;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_src_q    <= '0;
      cv_cru_q    <= '0;
      itag_q      <= '0;
      rtag_q      <= '0;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
      last_q      <= LW'(NREQ - 1);
    end else begin
      cv_cru_q <= |gnt ? {1'b1, rc[gid]} : 6'b0;
      if (|gnt) begin
        cv_src_q <= rd[gid];
        last_q   <= gid;
      end
      itag_q      <= {|gnt, gid};
      rtag_q      <= itag_q;
      busy_q      <= (busy_q | gnt) & ~done;
      rsp_valid_q <= (rsp_valid_q & ~done) | wr;
      if (rtag_q[LW]) begin
        rsp_data_q[rtag_q[LW-1:0]] <= cv_res;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
  assign req_ready = gnt;
  assign cv_src    = cv_src_q;
  assign cv_cru    = cv_cru_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign conv_cnt  = cnt_q;
endmodule

// File: tb/tb_inttofp_arb.sv
// tb_inttofp_arb: directed vector table plus hand-written sequences for inttofp_arb,
// with a behavioural int-to-fp converter on the cv_* side.
module tb_inttofp_arb;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, en = 0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*128-1:0] req_data = '0, rsp_data;
  logic [N*5-1:0] req_cru = '0;
  logic [127:0] cv_src, cv_res = '0;
  logic [5:0] cv_cru;
  logic [15:0] conv_cnt;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    int           rq;
    logic [127:0] data;
    logic [4:0]   cru;
    logic [127:0] expv;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  inttofp_arb #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_cru(req_cru), .en(en), .cv_src(cv_src), .cv_cru(cv_cru),
    .cv_res(cv_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .conv_cnt(conv_cnt)
  );

  // Round-to-nearest-even integer to fp32 (w32) or fp16 conversion of one lane.
  function automatic logic [31:0] cvt(logic [31:0] v, logic sgn, logic w32);
    longint mag, keep, rem, half;
    int p, m, sh;
    logic neg;
    m = w32 ? 23 : 10;
    neg = sgn & (w32 ? v[31] : v[15]);
    mag = w32 ? {32'b0, v} : {48'b0, v[15:0]};
    if (neg) mag = (w32 ? 64'h1_0000_0000 : 64'h1_0000) - mag;
    if (mag == 0) return 32'b0;
    p = 0;
    for (int b = 0; b < 32; b++) if (mag[b]) p = b;
    if (p <= m) keep = mag << (m - p);
    else begin
      sh = p - m;
      keep = mag >> sh;
      rem = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep[m+1]) begin
        keep = keep >> 1;
        p++;
      end
    end
    return w32 ? {neg, 8'(127 + p), keep[22:0]} : {16'b0, neg, 5'(15 + p), keep[9:0]};
  endfunction

  function automatic logic [127:0] conv(logic [127:0] s, logic [4:0] c);
    logic [127:0] r = '0;
    if (c[4]) for (int l = 0; l < 4; l++) r[32*l+:32] = cvt(s[32*l+:32], c[2], 1'b1);
    else for (int l = 0; l < 8; l++) r[16*l+:16] = cvt({16'b0, s[16*l+:16]}, c[2], 1'b0)[15:0];
    return r;
  endfunction

  always @(posedge clk) if (cv_cru[5]) cv_res <= conv(cv_src, cv_cru[4:0]);

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int acc, multi, cnt;
    logic saw;
    vt[0] = '{0, {4{32'h0000_0001}}, 5'b11100, {4{32'h3F80_0000}}};
    vt[1] = '{1, {4{32'hFFFF_FFFF}}, 5'b11100, {4{32'hBF80_0000}}};
    vt[2] = '{1, {4{32'hFFFF_FFFF}}, 5'b11000, {4{32'h4F80_0000}}};
    vt[3] = '{2, {8{16'h0002}},      5'b00100, {8{16'h4000}}};
    vt[4] = '{3, {4{32'd10}},        5'b11100, {4{32'h4120_0000}}};
    vt[5] = '{0, {4{32'hFFFF_FFFE}}, 5'b11100, {4{32'hC000_0000}}};

    // Reset state, with requests asserted to show req_ready is held low
    @(negedge clk);
    req_valid = '1;
    en = 1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_cv_cru", cv_cru, 0);
    chk("rst_cv_src", cv_src, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cnt", conv_cnt, 0);
    req_valid = '0;
    rst_n = 1;

    cnt = 0;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      req_data = {16{$urandom()}};
      req_cru = 20'($urandom());
      req_data[128*vt[v].rq+:128] = vt[v].data;
      req_cru[5*vt[v].rq+:5] = vt[v].cru;
      req_valid[vt[v].rq] = 1;
      #1 chk("vec_grant", req_ready, 1 << vt[v].rq);
      @(negedge clk);
      req_valid = '0;
      req_data = {16{$urandom()}};
      chk("vec_cv_cru", cv_cru, {1'b1, vt[v].cru});
      chk("vec_cv_src", cv_src, vt[v].data);
      @(negedge clk);
      chk("vec_rsp_early", rsp_valid, 0);
      @(negedge clk);
      cnt++;
      chk("vec_rsp_valid", rsp_valid, 1 << vt[v].rq);
      chk("vec_rsp_data", rsp_data[128*vt[v].rq+:128], vt[v].expv);
      chk("vec_cnt", conv_cnt, cnt);
      rsp_ready[vt[v].rq] = 1;
      @(negedge clk);
      rsp_ready = '0;
      chk("vec_consumed", rsp_valid, 0);
    end

    // Result held until consumed; no re-accept before the edge after consume
    @(negedge clk);
    req_data[256+:128] = {8{16'h0002}};
    req_cru[10+:5] = 5'b00100;
    req_valid[2] = 1;
    #1 chk("hold_grant", req_ready, 4'b0100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_data", rsp_data[256+:128], {8{16'h4000}});
      chk("hold_valid", rsp_valid, 4'b0100);
      chk("hold_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready[2] = 1;
    #1 chk("hold_ready_pulse", req_ready, 0);
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("hold_reready", req_ready, 4'b0100);
    chk("hold_consumed", rsp_valid, 0);
    req_valid = '0;

    // Round-robin streaming with all requesters valid
    do_reset();
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 12; k++) begin
      #1 chk("rr_grant", req_ready, 1 << (k % 4));
      @(negedge clk);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rr_cnt", conv_cnt, 12);
    chk("rr_drained", rsp_valid, 0);
    rsp_ready = '0;

    // en low blocks grants; reset mid-flight drops the conversion
    do_reset();
    en = 0;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("en_ready", req_ready, 0);
      chk("en_cv_valid", cv_cru[5], 0);
      @(negedge clk);
    end
    en = 1;
    req_valid = 4'b0001;
    #1 chk("en_grant", req_ready, 4'b0001);
    @(negedge clk);
    rst_n = 0;
    req_valid = '0;
    #1 chk("mid_rst_cv_cru", cv_cru, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_cnt", conv_cnt, 0);

    // Counter wrap after 65536 completions
    do_reset();
    req_valid = '1;
    rsp_ready = '1;
    acc = 0;
    multi = 0;
    saw = 0;
    for (int c = 0; c < 70000 && acc < 65536; c++) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (conv_cnt == 16'hFFFF) saw = 1;
      if (|(req_ready & req_valid)) acc++;
      @(negedge clk);
    end
    en = 0;
    chk("wrap_accepts", acc, 65536);
    for (int c = 0; c < 5; c++) begin
      #1 if (conv_cnt == 16'hFFFF) saw = 1;
      @(negedge clk);
    end
    chk("wrap_saw_ffff", saw, 1);
    chk("wrap_cnt", conv_cnt, 0);
    chk("wrap_onehot", multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
